// File: rtl/heepsilon_pkg.sv
// Shared types and constants for the external OBI address decoder slice.
// The optional error-capture ports of ext_obi_addr_decoder are enabled by
// defining EXT_DEC_ERR_CAPTURE_EN.
package heepsilon_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Address window; end_addr is exclusive.
    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned EXT_XBAR_NSLAVE = 1;
    localparam int unsigned LOG_EXT_XBAR_NSLAVE =
        (EXT_XBAR_NSLAVE > 1) ? $clog2(EXT_XBAR_NSLAVE) : 1;

    // Default map: CGRA context memory only.
    localparam addr_map_rule_t [EXT_XBAR_NSLAVE-1:0] EXT_XBAR_ADDR_RULES = {
        addr_map_rule_t'{start_addr: 32'hF000_0000, end_addr: 32'hF001_0000}
    };

    typedef struct packed {
        logic                           miss;
        logic [LOG_EXT_XBAR_NSLAVE-1:0] idx;
    } ext_dec_entry_t;

    localparam logic [31:0] EXT_DEC_ERR_RDATA       = 32'hBADACCE5;
    localparam int unsigned EXT_DEC_MAX_OUTSTANDING = 4;

    function automatic logic rule_hit(input addr_map_rule_t rule, input logic [31:0] addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/ext_dec_owner_fifo.sv
// Synchronous FIFO holding the owner of each outstanding OBI transaction.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module ext_dec_owner_fifo
    import heepsilon_pkg::*;
#(
    parameter int unsigned DEPTH = EXT_DEC_MAX_OUTSTANDING
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  ext_dec_entry_t               entry_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output ext_dec_entry_t               head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ext_dec_entry_t    mem [2**PTR_W];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              wr_en;
    logic              rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept only legal operations; callers may not rely on overflow/underflow.
    always_comb begin
        full_o  = (count == CNT_W'(DEPTH));
        empty_o = (count == '0);
        wr_en   = push_i & ~full_o;
        rd_en   = pop_i & ~empty_o;
        count_o = count;
        head_o  = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= entry_i;
    end

endmodule

// File: rtl/ext_obi_addr_decoder.sv
// Routes the MCU external OBI master to NSLAVE slaves by address rule,
// returns in-order responses and answers unmapped accesses with an error.
// Optional error-address capture: define EXT_DEC_ERR_CAPTURE_EN.
module ext_obi_addr_decoder
    import heepsilon_pkg::*;
#(
    parameter int unsigned                  NSLAVE          = EXT_XBAR_NSLAVE,
    parameter addr_map_rule_t [NSLAVE-1:0]  RULES           = EXT_XBAR_ADDR_RULES,
    parameter int unsigned                  MAX_OUTSTANDING = EXT_DEC_MAX_OUTSTANDING,
    parameter logic [31:0]                  ERR_RDATA       = EXT_DEC_ERR_RDATA
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  obi_req_t               master_req_i,
    output obi_resp_t              master_resp_o,
    output obi_req_t  [NSLAVE-1:0] slave_req_o,
    input  obi_resp_t [NSLAVE-1:0] slave_resp_i
`ifdef EXT_DEC_ERR_CAPTURE_EN
    ,
    input  logic                   err_clear_i,
    output logic                   err_valid_o,
    output logic [31:0]            err_addr_o
`endif
);

    localparam int unsigned IDX_W = LOG_EXT_XBAR_NSLAVE;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             dec_hit;
    logic             dec_miss;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_gnt;
    logic             head_rvalid;
    logic [31:0]      head_rdata;
    logic             grant;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    ext_dec_entry_t   head;
    ext_dec_entry_t   push_entry;
    logic             stray_rvalid;
    logic [CNT_W-1:0] orphans;

    // Address decode: lowest matching rule wins.
    always_comb begin
        dec_hit = 1'b0;
        hit_idx = '0;
        for (int unsigned k = 0; k < NSLAVE; k++) begin
            if (!dec_hit && rule_hit(RULES[k], master_req_i.addr)) begin
                dec_hit = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
        dec_miss = ~dec_hit;
    end

    // Select the grant of the addressed slave and the response of the head owner.
    always_comb begin
        hit_gnt     = 1'b0;
        head_rvalid = 1'b0;
        head_rdata  = '0;
        for (int unsigned k = 0; k < NSLAVE; k++) begin
            if (hit_idx == IDX_W'(k)) hit_gnt = slave_resp_i[k].gnt;
            if (head.idx == IDX_W'(k)) begin
                head_rvalid = slave_resp_i[k].rvalid;
                head_rdata  = slave_resp_i[k].rdata;
            end
        end
    end

    // Broadcast request fields; only the addressed slave sees req.
    always_comb begin
        for (int unsigned k = 0; k < NSLAVE; k++) begin
            slave_req_o[k]     = master_req_i;
            slave_req_o[k].req = master_req_i.req & ~fifo_full & ~rst_i
                                 & dec_hit & (hit_idx == IDX_W'(k));
        end
    end

    // Grant and response toward the master; everything is quiet during reset.
    always_comb begin
        grant = 1'b0;
        if (!rst_i && !fifo_full) begin
            grant = dec_miss ? master_req_i.req : hit_gnt;
        end
        master_resp_o     = '0;
        master_resp_o.gnt = grant;
        if (!rst_i && !fifo_empty) begin
            if (head.miss) begin
                master_resp_o.rvalid = 1'b1;
                master_resp_o.rdata  = ERR_RDATA;
            end else begin
                master_resp_o.rvalid = head_rvalid;
                master_resp_o.rdata  = head_rdata;
            end
        end
        push            = master_req_i.req & grant;
        pop             = master_resp_o.rvalid;
        push_entry.miss = dec_miss;
        push_entry.idx  = hit_idx;
    end

    ext_dec_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

    // Any slave rvalid not belonging to the head owner is dropped.
    always_comb begin
        stray_rvalid = 1'b0;
        for (int unsigned k = 0; k < NSLAVE; k++) begin
            if (slave_resp_i[k].rvalid &&
                (fifo_empty || head.miss || head.idx != IDX_W'(k))) begin
                stray_rvalid = 1'b1;
            end
        end
    end

    // Responses to transactions abandoned by a reset are expected stragglers,
    // not protocol errors; remember how many may still arrive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            orphans <= fifo_count;
        end else if (stray_rvalid && orphans != '0) begin
            orphans <= orphans - CNT_W'(1);
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(stray_rvalid && orphans == '0))
        else $error("ext_obi_addr_decoder: rvalid from a slave that does not own the head transaction");

`ifdef EXT_DEC_ERR_CAPTURE_EN
    // Sticky capture of the first unmapped address; a new miss beats a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end else if (push && dec_miss && (!err_valid_o || err_clear_i)) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= master_req_i.addr;
        end else if (err_clear_i) begin
            err_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/ext_obi_addr_decoder.md
Name: ext_obi_addr_decoder

Overview:
- Sits directly upstream of the external slave crossbar map (CGRA context memory and future external slaves), on the external OBI master port of the MCU.
- Routes one incoming OBI request stream to EXT_XBAR_NSLAVE OBI slave ports by matching the address against the address rule table.
- Routes in-order responses back, tracking the owner of each outstanding transaction in a small FIFO.
- Answers unmapped accesses itself with an error response, so the bus never hangs.

Parameters:
- NSLAVE, 1, number of slave ports (equals EXT_XBAR_NSLAVE).
- RULES, EXT_XBAR_ADDR_RULES, addr_map_rule_t array [NSLAVE-1:0]; end_addr is exclusive.
- MAX_OUTSTANDING, 4, depth of the outstanding-owner FIFO; must be at least 1.
- ERR_RDATA, 32'hBADACCE5, rdata returned for an unmapped access.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- master_req_i  in  obi_req_t  request from the MCU external master (req, we, be, addr, wdata)
- master_resp_o  out  obi_resp_t  gnt, rvalid, rdata to the master
- slave_req_o  out  obi_req_t [NSLAVE-1:0]  requests to the slaves
- slave_resp_i  in  obi_resp_t [NSLAVE-1:0]  responses from the slaves

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: FIFO empty (count=0); master_resp_o all zeros; every slave_req_o.req=0.
- Reset asserted mid-operation discards all outstanding entries. Slave rvalid arriving after reset is ignored, because the FIFO is empty.
- Decode (combinational):
  - hit_idx = lowest k with RULES[k].start_addr <= addr < RULES[k].end_addr.
  - miss when no rule matches.
  - Overlapping rules resolve to the lowest index.
- Request path, zero added latency:
  - we, be, addr, wdata are broadcast to all slaves.
  - slave_req_o[hit_idx].req = master.req & ~full. All other slave req signals are 0.
- Grant:
  - hit: gnt = slave_resp_i[hit_idx].gnt & ~full.
  - miss: gnt = master.req & ~full.
  - full (count==MAX_OUTSTANDING) blocks the grant even if a pop occurs in the same cycle.
- Push: on req&gnt, push the entry {miss, hit_idx}.
- Response path:
  - Head entry is a slave k: master rvalid/rdata = slave_resp_i[k] combinationally, and pop on that rvalid.
  - Head entry is a miss: rvalid=1 and rdata=ERR_RDATA in the first cycle that entry is at the head (at least 1 cycle after its grant), then pop. Writes to unmapped space are also acknowledged with rvalid.
  - Slaves respond in order. rvalid from a non-head slave, or rvalid with an empty FIFO, is a protocol violation: it is dropped and flagged by a simulation assertion.
- Simultaneous push and pop in one cycle: count is unchanged; the pointers wrap modulo MAX_OUTSTANDING.
- Throughput: back-to-back grants are allowed every cycle until full.

Optional Feature:
- Macro: EXT_DEC_ERR_CAPTURE_EN.
- Defined: adds three ports.
  - err_clear_i  in  1
  - err_valid_o  out  1
  - err_addr_o  out  32
- On a granted miss with err_valid_o=0, the block latches addr and sets err_valid_o (sticky; the first error wins).
- err_clear_i clears err_valid_o. If a clear and a new miss occur in the same cycle, the new miss wins: err_valid_o stays 1 with the new address.
- Both outputs reset to 0.
- Undefined: the ports are absent; miss handling is otherwise identical.

Decomposition:
- Shared package (heepsilon_pkg):
  - ext_dec_entry_t {logic miss; logic [LOG_EXT_XBAR_NSLAVE-1:0] idx}
  - EXT_DEC_ERR_RDATA constant
  - EXT_DEC_MAX_OUTSTANDING constant
- Sub-module ext_dec_owner_fifo: a generic synchronous FIFO of ext_dec_entry_t with push, pop, full, empty and head outputs.

Test Plan:
Bench uses NSLAVE=2 with rules [0x1000_0000,0x1010_0000) and [0x1010_0000,0x1020_0000).
- Read 0x1000_0040, slave0 gnt in the same cycle, rvalid 2 cycles later with rdata 0x1234_5678 -> slave0 req only; master sees gnt in the same cycle, then rvalid with 0x1234_5678.
- Read 0x1010_0000 (the boundary) -> routed to slave1. Read 0x100F_FFFC -> routed to slave0.
- Write to 0x2000_0000 -> gnt in the same cycle; rvalid 1 cycle later with rdata 0xBADACCE5; no slave req. With EXT_DEC_ERR_CAPTURE_EN: err_valid_o=1 and err_addr_o=0x2000_0000.
- Slaves hold rvalid low and the master issues 5 back-to-back reads to slave0 -> 4 grants, 5th gnt held low until the first rvalid; then granted.
- Interleaved slave1 read, miss, slave0 read -> responses return in that order with the correct rdata; slave1 delaying 3 cycles delays the miss response accordingly.
- Two outstanding reads, then rst_i pulsed for 1 cycle, then slave0 rvalid -> master rvalid stays 0; count=0; gnt resumes the cycle after reset.
